// File: rtl/sys_defs.sv
// Shared definitions for the load buffer: widths, load packet and CDB result
// formats, load-buffer FSM states and the funct3 load-size encodings.
package sys_defs;

  localparam int XLEN      = 32;
  localparam int ROB_TAG_W = 5;
  localparam int LB_DEPTH  = 4;

  typedef enum logic [2:0] {
    LB_IDLE,
    LB_REQ,
    LB_WAIT,
    LB_BCAST,
    LB_DRAIN
  } LB_STATE;

  // funct3 encodings of the integer load instructions
  typedef enum logic [2:0] {
    MEM_LB  = 3'b000,
    MEM_LH  = 3'b001,
    MEM_LW  = 3'b010,
    MEM_LBU = 3'b100,
    MEM_LHU = 3'b101
  } MEM_SIZE;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      address;
    logic [ROB_TAG_W-1:0] rd_tag;
    MEM_SIZE              mem_size;
  } LB_PACKET;

  // What a queued entry keeps once accepted; valid is implied by occupancy.
  typedef struct packed {
    logic [XLEN-1:0]      address;
    logic [ROB_TAG_W-1:0] rd_tag;
    MEM_SIZE              mem_size;
  } LB_ENTRY;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      value;
    logic [ROB_TAG_W-1:0] rob_tag;
  } CDB_DATA;

endpackage

// File: rtl/load_data_align.sv
// Extracts the addressed byte/halfword from a 32-bit memory word and
// sign- or zero-extends it according to the load's funct3.
module load_data_align
  import sys_defs::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      address,
  input  MEM_SIZE         mem_size,
  output logic [XLEN-1:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{address, 3'b000} +: 8];
    half_sel = address[1] ? word[31:16] : word[15:0];
    case (mem_size)
      MEM_LB:  value = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: value = {24'h0, byte_sel};
      MEM_LH:  value = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: value = {16'h0, half_sel};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/load_buffer.sv
// In-order load buffer: queues address-calculated loads in a circular FIFO and
// runs one memory read at a time for the head entry, broadcasting on the CDB.
module load_buffer
  import sys_defs::*;
#(
  parameter int LB_DEPTH = sys_defs::LB_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  LB_PACKET        lb_packet_in,
  input  logic            squash,
  output logic            lb_full,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output CDB_DATA         cdb_out,
  input  logic            cdb_grant
);

  localparam int PTR_W = $clog2(LB_DEPTH);

  LB_ENTRY          entries [LB_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count, count_next;
  LB_STATE          state, state_next;
  logic [XLEN-1:0]  result, aligned;
  logic             push, pop;
  LB_ENTRY          head_entry;

  assign head_entry = entries[head];
  assign lb_full    = (count == (PTR_W+1)'(LB_DEPTH));
  assign push       = lb_packet_in.valid & ~lb_full & ~squash;
  assign pop        = (state == LB_BCAST) & cdb_grant & ~squash;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  // NOTE: the entry array has no reset; occupancy is tracked by count/head/tail,
  // so stale contents are never observed and the RAM stays reset-free.
  always_ff @(posedge clk) begin
    if (push) entries[tail] <= '{address:  lb_packet_in.address,
                                 rd_tag:   lb_packet_in.rd_tag,
                                 mem_size: lb_packet_in.mem_size};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LB_IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      if (squash) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        count <= count_next;
      end
    end
  end

  load_data_align u_align (
    .word     (mem_resp_data),
    .address  (head_entry.address[1:0]),
    .mem_size (head_entry.mem_size),
    .value    (aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    result <= '0;
    else if (state == LB_WAIT && mem_resp_valid)   result <= aligned;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      LB_IDLE:  if (push || count != '0) state_next = LB_REQ;
      LB_REQ:   if (mem_req_ready)       state_next = LB_WAIT;
      LB_WAIT:  if (mem_resp_valid)      state_next = LB_BCAST;
      LB_BCAST: if (cdb_grant)           state_next = (count_next != '0) ? LB_REQ : LB_IDLE;
      LB_DRAIN: if (mem_resp_valid)      state_next = (count_next != '0) ? LB_REQ : LB_IDLE;
      default:                           state_next = LB_IDLE;
    endcase
    // A response still owed by memory must be swallowed before restarting.
    if (squash) begin
      if ((state == LB_WAIT || state == LB_DRAIN) && !mem_resp_valid) state_next = LB_DRAIN;
      else                                                            state_next = LB_IDLE;
    end
  end

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    cdb_out       = '0;
    if (state == LB_REQ) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = head_entry.address;
    end
    if (state == LB_BCAST) begin
      cdb_out.valid   = 1'b1;
      cdb_out.value   = result;
      cdb_out.rob_tag = head_entry.rd_tag;
    end
  end

endmodule

// File: tb/tb_load_buffer.sv
// Directed bench for load_buffer: ordering, alignment, backpressure, squash
// and asynchronous reset, with hand-computed expected values.
module tb_load_buffer;
  import sys_defs::*;

  logic            clk = 1'b0;
  logic            rst_n;
  LB_PACKET        pkt;
  logic            squash;
  logic            lb_full;
  logic            mem_req_valid;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_ready;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;
  CDB_DATA         cdb_out;
  logic            cdb_grant;

  int checks = 0;
  int errors = 0;

  load_buffer #(.LB_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lb_packet_in   (pkt),
    .squash         (squash),
    .lb_full        (lb_full),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .cdb_out        (cdb_out),
    .cdb_grant      (cdb_grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_load(input logic [31:0] addr, input logic [4:0] tag, input MEM_SIZE size);
    pkt = '{valid: 1'b1, address: addr, rd_tag: tag, mem_size: size};
    tick();
    pkt.valid = 1'b0;
  endtask

  // From REQ: accept the request, idle one cycle in WAIT, then respond.
  task automatic serve(input logic [31:0] data);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    tick();
    mem_resp_valid = 1'b0;
  endtask

  task automatic expect_bcast(input string tag, input logic [4:0] rob_tag, input logic [31:0] value);
    check({tag, ".valid"}, 64'(cdb_out.valid), 64'd1);
    check({tag, ".value"}, 64'(cdb_out.value), 64'(value));
    check({tag, ".tag"},   64'(cdb_out.rob_tag), 64'(rob_tag));
  endtask

  task automatic grant();
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
  endtask

  task automatic full_load(input string tag, input logic [31:0] addr, input logic [4:0] rob_tag,
                           input MEM_SIZE size, input logic [31:0] data, input logic [31:0] value);
    push_load(addr, rob_tag, size);
    check({tag, ".addr"}, 64'(mem_req_addr), 64'(addr));
    serve(data);
    expect_bcast(tag, rob_tag, value);
    grant();
  endtask

  initial begin
    rst_n = 1'b0;
    pkt = '0;
    squash = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    cdb_grant = 1'b0;
    #12;
    check("reset.full", 64'(lb_full), 64'd0);
    check("reset.req", 64'(mem_req_valid), 64'd0);
    check("reset.cdb", 64'(cdb_out), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic LW with response delay and grant backpressure
    push_load(32'h100, 5'd5, MEM_LW);
    check("lw.req_valid", 64'(mem_req_valid), 64'd1);
    check("lw.req_addr", 64'(mem_req_addr), 64'h100);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("lw.wait_req", 64'(mem_req_valid), 64'd0);
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'hDEADBEEF;
    check("lw.no_early_cdb", 64'(cdb_out.valid), 64'd0);
    tick();
    mem_resp_valid = 1'b0;
    expect_bcast("lw.bcast", 5'd5, 32'hDEADBEEF);
    tick();
    expect_bcast("lw.hold", 5'd5, 32'hDEADBEEF);
    grant();
    check("lw.idle_cdb", 64'(cdb_out.valid), 64'd0);
    check("lw.idle_req", 64'(mem_req_valid), 64'd0);

    // Alignment and extension
    full_load("lb",  32'h103, 5'd6, MEM_LB,  32'h80FFFF12, 32'hFFFFFF80);
    full_load("lhu", 32'h102, 5'd7, MEM_LHU, 32'h80FFFF12, 32'h000080FF);
    full_load("lbu", 32'h101, 5'd8, MEM_LBU, 32'h80FFFF12, 32'h000000FF);
    full_load("lh",  32'h102, 5'd9, MEM_LH,  32'h80FFFF12, 32'hFFFF80FF);
    full_load("lb0", 32'h100, 5'd3, MEM_LB,  32'h80FFFF12, 32'h00000012);

    // Fill to full with memory stalled; fifth push dropped
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("fill%0d.full_before", i), 64'(lb_full), 64'd0);
      push_load(32'h200 + 32'(4 * (i - 1)), 5'(i), MEM_LW);
    end
    check("fill.full", 64'(lb_full), 64'd1);
    push_load(32'h2F0, 5'd9, MEM_LW);
    check("fill.still_full", 64'(lb_full), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("fill%0d.addr", i), 64'(mem_req_addr), 64'h200 + 64'(4 * (i - 1)));
      serve(32'h1000 + 32'(i));
      expect_bcast($sformatf("fill%0d", i), 5'(i), 32'h1000 + 32'(i));
      grant();
    end
    check("fill.no_fifth_req", 64'(mem_req_valid), 64'd0);
    check("fill.no_fifth_cdb", 64'(cdb_out.valid), 64'd0);
    check("fill.empty", 64'(lb_full), 64'd0);

    // Grant stall, then push+pop in the same cycle
    push_load(32'h400, 5'd10, MEM_LW);
    push_load(32'h404, 5'd11, MEM_LW);
    serve(32'hAAAA5555);
    for (int i = 0; i < 5; i++) begin
      expect_bcast($sformatf("stall%0d", i), 5'd10, 32'hAAAA5555);
      tick();
    end
    cdb_grant = 1'b1;
    pkt = '{valid: 1'b1, address: 32'h408, rd_tag: 5'd12, mem_size: MEM_LW};
    tick();
    cdb_grant = 1'b0;
    pkt.valid = 1'b0;
    check("pp.addr", 64'(mem_req_addr), 64'h404);
    push_load(32'h40C, 5'd13, MEM_LW);
    check("pp.count3", 64'(lb_full), 64'd0);
    push_load(32'h410, 5'd14, MEM_LW);
    check("pp.count4", 64'(lb_full), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pp%0d.addr", i), 64'(mem_req_addr), 64'h404 + 64'(4 * i));
      serve(32'h2000 + 32'(i));
      expect_bcast($sformatf("pp%0d", i), 5'(11 + i), 32'h2000 + 32'(i));
      grant();
    end
    check("pp.done", 64'(mem_req_valid), 64'd0);

    // Squash in WAIT; late response discarded; push during DRAIN completes
    push_load(32'h500, 5'd20, MEM_LW);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    squash = 1'b1;
    tick();
    squash = 1'b0;
    check("sq.req", 64'(mem_req_valid), 64'd0);
    check("sq.cdb", 64'(cdb_out.valid), 64'd0);
    push_load(32'h300, 5'd21, MEM_LW);
    check("sq.drain_req", 64'(mem_req_valid), 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h0BAD0BAD;
    tick();
    mem_resp_valid = 1'b0;
    check("sq.no_bcast", 64'(cdb_out.valid), 64'd0);
    check("sq.new_req", 64'(mem_req_valid), 64'd1);
    check("sq.new_addr", 64'(mem_req_addr), 64'h300);
    serve(32'h00000055);
    expect_bcast("sq.after", 5'd21, 32'h55);
    grant();
    check("sq.empty", 64'(cdb_out.valid), 64'd0);

    // Asynchronous reset in REQ with 3 entries
    push_load(32'h600, 5'd30, MEM_LW);
    push_load(32'h604, 5'd31, MEM_LW);
    push_load(32'h608, 5'd32 - 5'd1, MEM_LW);
    check("rst.pre_req", 64'(mem_req_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst.req", 64'(mem_req_valid), 64'd0);
    check("rst.addr", 64'(mem_req_addr), 64'd0);
    check("rst.cdb", 64'(cdb_out), 64'd0);
    check("rst.full", 64'(lb_full), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h77777777;
    tick();
    mem_resp_valid = 1'b0;
    tick();
    check("rst.stray_cdb", 64'(cdb_out.valid), 64'd0);
    check("rst.stray_req", 64'(mem_req_valid), 64'd0);
    full_load("rst.after", 32'h700, 5'd2, MEM_LW, 32'h12345678, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
